// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: datapath widths, the fetch buffer entry and
// the fetch control states.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } fetch_state_e;

endpackage : riscv_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and a flush that empties the
// buffer in one cycle. DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            w_full;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~w_full | i_pop);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: storage has no reset; the count and pointers alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order requests to instruction memory, buffered
// responses to decode, and redirect handling that discards wrong-path words.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  fetch_state_e    r_state;

  logic [XLEN-1:0] w_target;
  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   w_drop_cnt_next;
  logic [CW:0]     w_in_use;
  fetch_state_e    w_state_next;
  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_target = redirect_pc & ~32'h0000_0003;

  // Requests in flight plus buffered words never exceed the buffer size, so
  // every response is guaranteed a slot.
  assign w_in_use       = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = ~reset & fetch_en & ~redirect_valid & (w_in_use < DEPTH_C);
  assign imem_addr      = r_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_drop       = imem_rsp_valid & (r_state == ST_DRAIN);
  assign w_push       = imem_rsp_valid & ~w_drop & ~redirect_valid;
  assign w_pop        = ~w_empty & id_ready & ~redirect_valid;
  assign w_push_entry = '{pc: r_rsp_pc, inst: imem_rsp_data};

  assign w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

  always_comb begin
    w_drop_cnt_next = r_drop_cnt;
    if (redirect_valid)  w_drop_cnt_next = w_outstanding_next;
    else if (w_drop)     w_drop_cnt_next = r_drop_cnt - CW'(1);
    w_state_next = (w_drop_cnt_next != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
      end else begin
        if (w_accept) r_pc     <= r_pc + 32'd4;
        if (w_push)   r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redirect_valid),
    .i_data (w_push_entry),
    .o_head (w_head),
    .o_empty(w_empty),
    .o_count(w_fifo_count)
  );

  assign id_valid = ~w_empty;
  assign id_inst  = w_head.inst;
  assign id_pc    = w_head.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers accepted requests in
// order, and every non-discarded word is queued as the expected decode output.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_pc;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           accepts  = 0;
  bit           rsp_hold = 1'b0;
  logic         s_id_valid;
  logic         s_req_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit redir, input logic [31:0] target);
    mreq_t        r;
    fetch_entry_t e;
    bit           rsp;
    r = '{addr: 32'h0, stale: 1'b0};
    redirect_valid = redir;
    redirect_pc    = target;
    rsp = !rsp_hold && (mem_q.size() > 0);
    if (rsp) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(r.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_id_valid  = id_valid;
    s_req_valid = imem_req_valid;
    if (redir) check("no_req_on_redirect", {31'b0, imem_req_valid}, 32'h0);
    if (imem_req_valid && !imem_req_ready) check("addr_stall_stable", imem_addr, exp_pc);
    if (id_valid && id_ready && !redir) begin
      check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_inst", id_inst, e.inst);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("fetch_addr", imem_addr, exp_pc);
      mem_q.push_back('{addr: imem_addr, stale: 1'b0});
      exp_pc += 32'd4;
      accepts++;
    end
    if (rsp && !r.stale && !redir) exp_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
    if (redir) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_pc = {target[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    exp_pc = RST_PC;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming: one cycle from response to id_valid, then no gaps.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0);
      check($sformatf("stream_id_valid_%0d", i), {31'b0, s_id_valid}, (i >= 2) ? 32'h1 : 32'h0);
    end

    // Decode stall: the buffer fills and issue stops.
    id_ready = 1'b0;
    accepts  = 0;
    run(10);
    check("stall_accepts_le_depth", {31'b0, accepts <= DEPTH}, 32'h1);
    check("stall_req_low", {31'b0, s_req_valid}, 32'h0);
    id_ready = 1'b1;
    step(1'b0, 32'h0);
    check("req_low_on_first_pop", {31'b0, s_req_valid}, 32'h0);
    run(8);

    // Drain, then build 2 outstanding + 2 buffered and redirect.
    fetch_en = 1'b0;
    run(8);
    check("drained_empty", {31'b0, s_id_valid}, 32'h0);
    fetch_en = 1'b1; id_ready = 1'b0;
    run(3);
    rsp_hold = 1'b1;
    run(2);
    check("full_budget_req_low", {31'b0, s_req_valid}, 32'h0);
    step(1'b1, 32'h0000_0100);
    rsp_hold = 1'b0; id_ready = 1'b1;
    step(1'b0, 32'h0);
    check("redirect_fifo_empty", {31'b0, s_id_valid}, 32'h0);
    run(10);

    // Redirect while a response arrives and decode is popping.
    step(1'b1, 32'h0000_3000);
    step(1'b0, 32'h0);
    check("redirect_rsp_fifo_empty", {31'b0, s_id_valid}, 32'h0);
    run(8);

    // Memory stall with a misaligned redirect target.
    imem_req_ready = 1'b0;
    accepts = 0;
    step(1'b1, 32'h0000_0203);
    #1 check("misaligned_target_addr", imem_addr, 32'h0000_0200);
    @(negedge clk);
    run(5);
    check("no_accept_while_stalled", accepts, 32'h0);
    imem_req_ready = 1'b1;
    run(8);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8);
    run(8);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    check("async_rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    accepts = 0;
    run(8);
    check("post_reset_accepts", {31'b0, accepts > 0}, 32'h1);

    // Final drain: everything expected must have reached decode.
    fetch_en = 1'b0;
    run(8);
    check("sb_drained", exp_q.size(), 32'h0);
    check("final_id_valid", {31'b0, s_id_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
